// File: rtl/demux_1to16_deser_if.sv
// demux_1to16_deser_if: serial input, slot select and deserialized frame outputs
interface demux_1to16_deser_if #(parameter int SEL_W = 4);
  localparam int N = 2 ** SEL_W;
  logic             in;
  logic             in_valid;
  logic [SEL_W-1:0] sel;
  logic             mode;
  logic             clear;
  logic [N-1:0]     out;
  logic [SEL_W-1:0] ptr;
  logic             busy;
  logic [N-1:0]     frame_out;
  logic             frame_valid;
  logic [7:0]       frame_cnt;
  modport master (output in, in_valid, sel, mode, clear,
                  input out, ptr, busy, frame_out, frame_valid, frame_cnt);
  modport slave (input in, in_valid, sel, mode, clear,
                 output out, ptr, busy, frame_out, frame_valid, frame_cnt);
endinterface

// File: rtl/demux_1to16_deser.sv
// demux_1to16_deser: routes a serial bit to an addressed or sequential slot and
// snapshots each completed sequential frame of 16 bits.
module demux_1to16_deser #(parameter int SEL_W = 4) (
  input logic clk,
  input logic rst_n,
  demux_1to16_deser_if.slave bus
);
  localparam int N = 2 ** SEL_W;
  typedef enum logic {IDLE, FILL} state_t;
  state_t           state_q, state_d;
  logic [N-1:0]     out_q, out_d, frame_out_q, frame_out_d;
  logic [SEL_W-1:0] ptr_q, ptr_d, slot;
  logic             frame_valid_q, frame_valid_d, seq_wr, last;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  assign seq_wr = bus.in_valid & bus.mode & ~bus.clear;
  assign last   = seq_wr & (ptr_q == SEL_W'(N - 1));
  assign slot   = bus.mode ? ptr_q : bus.sel;
  always_comb begin
    out_d = out_q;
    if (bus.clear) out_d = '0;
    else if (bus.in_valid) out_d[slot] = bus.in;
  end
  // On the closing write slot N-1 is the one being written, so out_d is the full frame
  assign frame_out_d   = last ? out_d : frame_out_q;
  assign frame_valid_d = last;
  assign frame_cnt_d   = frame_cnt_q + {7'd0, last};
  assign ptr_d   = bus.clear ? '0 : seq_wr ? ptr_q + 1'b1 : ptr_q;
  assign state_d = bus.clear ? IDLE : seq_wr ? (last ? IDLE : FILL) : state_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      out_q         <= '0;
      ptr_q         <= '0;
      frame_out_q   <= '0;
      frame_valid_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      out_q         <= out_d;
      ptr_q         <= ptr_d;
      frame_out_q   <= frame_out_d;
      frame_valid_q <= frame_valid_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end
  assign bus.out         = out_q;
  assign bus.ptr         = ptr_q;
  assign bus.busy        = (state_q == FILL);
  assign bus.frame_out   = frame_out_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_demux_1to16_deser.sv
// tb_demux_1to16_deser: per-cycle scoreboard of a reference model plus a queue
// of expected frames matched against every frame_valid pulse.
module tb_demux_1to16_deser;
  logic clk, rst_n;
  demux_1to16_deser_if bus ();
  demux_1to16_deser dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  typedef struct {
    logic [15:0] out;
    logic [3:0]  ptr;
    logic        busy;
    logic        fv;
    logic [15:0] fo;
    logic [7:0]  cnt;
  } exp_t;
  exp_t        sb[$];
  logic [15:0] fq[$];
  logic [15:0] m_out, m_fo;
  logic [3:0]  m_ptr;
  logic        m_fill, m_fv;
  logic [7:0]  m_cnt;
  int          n_chk = 0, n_pass = 0, fv_n = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic do_rst();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out", bus.out, 0);
    chk("rst_ptr", bus.ptr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_fo", bus.frame_out, 0);
    chk("rst_fv", bus.frame_valid, 0);
    chk("rst_cnt", bus.frame_cnt, 0);
    m_out = 0; m_fo = 0; m_ptr = 0; m_fill = 0; m_fv = 0; m_cnt = 0;
    fq.delete();
    #1 rst_n = 1'b1;
  endtask
  task automatic cyc(input logic b, input logic v, input logic [3:0] s, input logic m, input logic c);
    exp_t e;
    bus.in = b; bus.in_valid = v; bus.sel = s; bus.mode = m; bus.clear = c;
    m_fv = 1'b0;
    if (c) begin
      m_out = 0; m_ptr = 0; m_fill = 0;
    end else if (v && !m) begin
      m_out[s] = b;
    end else if (v) begin
      m_out[m_ptr] = b;
      if (m_ptr == 4'd15) begin
        m_fo = m_out; m_cnt++; m_fv = 1'b1; m_fill = 1'b0;
        fq.push_back(m_out);
      end else m_fill = 1'b1;
      m_ptr++;
    end
    e.out = m_out; e.ptr = m_ptr; e.busy = m_fill; e.fv = m_fv; e.fo = m_fo; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("out", bus.out, e.out);
    chk("ptr", bus.ptr, e.ptr);
    chk("busy", bus.busy, e.busy);
    chk("frame_valid", bus.frame_valid, e.fv);
    chk("frame_out", bus.frame_out, e.fo);
    chk("frame_cnt", bus.frame_cnt, e.cnt);
    if (bus.frame_valid) begin
      fv_n++;
      chk("frame_pending", fq.size() > 0, 1);
      if (fq.size() > 0) chk("frame_sb", bus.frame_out, fq.pop_front());
    end
  endtask
  initial begin
    logic [15:0] d;
    rst_n = 1'b0;
    bus.in = 0; bus.in_valid = 0; bus.sel = 0; bus.mode = 0; bus.clear = 0;
    do_rst();
    for (int i = 0; i < 16; i++) cyc(i[0], 1, 4'(i), 0, 0);
    chk("sweep_out", bus.out, 16'hAAAA);
    chk("sweep_ptr", bus.ptr, 0);
    chk("sweep_fv_n", fv_n, 0);
    cyc(0, 0, 0, 0, 1);
    d = 16'hC3A5;
    for (int i = 0; i < 16; i++) cyc(d[i], 1, 4'($urandom_range(15)), 1, 0);
    chk("seq_fo", bus.frame_out, 16'hC3A5);
    chk("seq_fv", bus.frame_valid, 1);
    chk("seq_cnt", bus.frame_cnt, 1);
    chk("seq_ptr", bus.ptr, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 1, 3, 0, 0);
    chk("ilv_ptr", bus.ptr, 8);
    chk("ilv_busy", bus.busy, 1);
    for (int i = 0; i < 8; i++) cyc(0, 1, 4'($urandom_range(15)), 1, 0);
    chk("ilv_fo", bus.frame_out, 16'h00F7);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 1, 0);
    chk("clr_ptr5", bus.ptr, 5);
    cyc(1, 1, 0, 1, 1);
    chk("clr_out", bus.out, 0);
    chk("clr_ptr", bus.ptr, 0);
    chk("clr_busy", bus.busy, 0);
    chk("clr_cnt", bus.frame_cnt, 2);
    for (int i = 0; i < 10; i++) cyc(1'($urandom_range(1)), 1, 0, 1, 0);
    chk("ar_ptr10", bus.ptr, 10);
    do_rst();
    for (int i = 0; i < 16; i++) cyc(1'($urandom_range(1)), 1, 0, 1, 0);
    chk("ar_cnt", bus.frame_cnt, 1);
    chk("ar_fv", bus.frame_valid, 1);
    do_rst();
    fv_n = 0;
    for (int f = 0; f < 256; f++)
      for (int i = 0; i < 16; i++) cyc(1'($urandom_range(1)), 1, 4'($urandom_range(15)), 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("wrap_cnt", bus.frame_cnt, 0);
    chk("wrap_pulses", fv_n, 256);
    chk("wrap_q_empty", fq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
